// File: rtl/qar_mem_arbiter.sv
// qar_mem_arbiter: lets the qar_core fetch port and data port share one
// single-port synchronous SRAM. Data requests win a tie, except that fetch
// wins once data has been granted MAX_DATA_STREAK times in a row while a
// fetch was waiting. Every access takes IDLE -> ACCESS -> RESP. Illegal
// addresses never strobe the SRAM, but they still complete with err set.
module qar_mem_arbiter #(
    parameter int DEPTH           = 64,
    parameter int ADDR_WIDTH      = 6,
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_addr,
    output logic                  imem_ready,
    output logic [31:0]           imem_rdata,
    output logic                  imem_err,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_err,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Index 0 is the fetch port and index 1 is the data port, so the
    // grant_data bit can select the winning port directly.
    localparam int PORT_COUNT = 2;

    localparam logic [ADDR_WIDTH:0]     DEPTH_LIMIT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_DATA_STREAK);
    localparam logic [STREAK_WIDTH-1:0] STREAK_SAT   = {STREAK_WIDTH{1'b1}};

    state_t state_reg;
    state_t state_next;

    logic [STREAK_WIDTH-1:0] streak_reg;
    logic [STREAK_WIDTH-1:0] streak_next;

    logic                  sram_en_reg;
    logic                  sram_we_reg;
    logic [ADDR_WIDTH-1:0] sram_addr_reg;
    logic [31:0]           sram_wdata_reg;
    logic                  illegal_reg;
    logic                  owner_data_reg;

    logic [PORT_COUNT-1:0][31:0]           port_addr;
    logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] port_index;
    logic [PORT_COUNT-1:0]                 port_illegal;

    logic grant_any;
    logic grant_data;
    logic grant_now;
    logic read_ok;

    assign port_addr = {mem_addr, imem_addr};

    // Decode each port's byte address into a word index and an illegal flag.
    // The flag covers misalignment, any set bit above the index, and an
    // index past the end of the array when DEPTH is not a power of two.
    generate
        for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_decode
            assign port_index[gi]   = port_addr[gi][ADDR_WIDTH+1:2];
            assign port_illegal[gi] = (port_addr[gi][1:0] != 2'b00)
                                   || (port_addr[gi][31:ADDR_WIDTH+2] != '0)
                                   || ({1'b0, port_index[gi]} >= DEPTH_LIMIT);
        end
    endgenerate

    // Pick a winner. Data wins a tie until the streak limit is reached.
    always_comb begin
        grant_any  = imem_valid || mem_valid;
        grant_data = 1'b0;
        if (mem_valid && imem_valid) begin
            grant_data = (streak_reg < STREAK_LIMIT);
        end else begin
            grant_data = mem_valid;
        end
    end

    // Requests are sampled only in IDLE. What the ports do afterwards is
    // ignored until the access has finished.
    assign grant_now = (state_reg == IDLE) && grant_any;

    // Count the data grants taken while a fetch was waiting. The count
    // clears whenever fetch wins or data wins with no fetch pending.
    always_comb begin
        streak_next = streak_reg;
        if (grant_now) begin
            if (grant_data && imem_valid) begin
                streak_next = (streak_reg == STREAK_SAT) ? streak_reg
                                                         : streak_reg + 1'b1;
            end else begin
                streak_next = '0;
            end
        end
    end

    // State register. An asynchronous reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. ACCESS and RESP each last exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's request at the grant edge. The SRAM strobe is
    // raised only for a legal address and is dropped when ACCESS ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_reg     <= '0;
            sram_en_reg    <= 1'b0;
            sram_we_reg    <= 1'b0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
            illegal_reg    <= 1'b0;
            owner_data_reg <= 1'b0;
        end else begin
            streak_reg <= streak_next;
            if (grant_now) begin
                owner_data_reg <= grant_data;
                sram_we_reg    <= grant_data && mem_we;
                sram_addr_reg  <= port_index[grant_data];
                sram_wdata_reg <= grant_data ? mem_wdata : 32'h0;
                illegal_reg    <= port_illegal[grant_data];
                sram_en_reg    <= !port_illegal[grant_data];
            end else if (state_reg == ACCESS) begin
                sram_en_reg <= 1'b0;
            end
        end
    end

    assign sram_en    = sram_en_reg;
    assign sram_we    = sram_we_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_wdata = sram_wdata_reg;

    // SRAM read data is passed back only for a legal read. Writes and
    // illegal accesses return zero.
    assign read_ok = !sram_we_reg && !illegal_reg;

    // Drive the response outputs. Only the owner sees ready, rdata and err,
    // and only during RESP, so the two ready outputs can never overlap.
    always_comb begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        imem_err   = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ACCESS: busy = 1'b1;
            RESP: begin
                busy = 1'b1;
                if (owner_data_reg) begin
                    mem_ready = 1'b1;
                    mem_err   = illegal_reg;
                    mem_rdata = read_ok ? sram_rdata : 32'h0;
                end else begin
                    imem_ready = 1'b1;
                    imem_err   = illegal_reg;
                    imem_rdata = read_ok ? sram_rdata : 32'h0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Testbench for qar_mem_arbiter. Stimulus is issued in batches. For each
// batch a reference model predicts the grant order and the expected
// responses and SRAM accesses, and queues them. A separate monitor pops
// and compares each time the DUT presents an SRAM strobe or a ready.
module tb_qar_mem_arbiter;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int MAXS  = 4;
    localparam int SW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_valid = 1'b0;
    logic [31:0]   imem_addr = '0;
    logic          imem_ready;
    logic [31:0]   imem_rdata;
    logic          imem_err;
    logic          mem_valid = 1'b0;
    logic          mem_we = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          mem_err;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic          busy;

    always #5 clk = ~clk;

    qar_mem_arbiter #(
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(MAXS), .STREAK_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    // Behavioural SRAM. The preload port fills it during reset.
    logic [31:0]   sram_mem [DEPTH];
    logic          preload_en = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [31:0]   preload_data = '0;
    int            wr_count = 0;

    always @(posedge clk) begin
        if (preload_en) begin
            sram_mem[preload_addr] <= preload_data;
        end else if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr] <= sram_wdata;
                wr_count <= wr_count + 1;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } op_t;
    typedef struct packed { logic [31:0] rdata; logic err; logic [31:0] addr; logic we; } resp_t;
    typedef struct packed { logic [AW-1:0] addr; logic we; logic [31:0] wdata; } acc_t;

    op_t   dq[$];
    op_t   fq[$];
    resp_t mem_q[$];
    resp_t imem_q[$];
    bit    order_q[$];
    acc_t  acc_q[$];

    logic [31:0] model_mem [DEPTH];
    int          model_streak = 0;
    int          tests = 0;
    int          fails = 0;
    int          busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: unexpected event at t=%0t", name, $time);
    endtask

    function automatic op_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        op_t o;
        o.we    = we;
        o.addr  = addr;
        o.wdata = wdata;
        return o;
    endfunction

    // A legal address is a word-aligned byte address inside the array.
    function automatic bit is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       return (32'($urandom_range(0, DEPTH - 1)) * 4) + 32'($urandom_range(1, 3));
            1:       return 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
            2:       return 32'h8000_0000 | (32'($urandom_range(0, DEPTH - 1)) * 4);
            default: return 32'($urandom_range(0, 15)) * 4;
        endcase
    endfunction

    function automatic logic outs_or();
        return |{imem_ready, imem_rdata, imem_err, mem_ready, mem_rdata, mem_err,
                 sram_en, sram_we, sram_addr, sram_wdata, busy};
    endfunction

    // Apply one granted operation to the model and queue its expected effects.
    task automatic predict(input bit is_data, input op_t o);
        resp_t r;
        acc_t  ac;
        int    w;
        r.addr  = o.addr;
        r.we    = is_data ? o.we : 1'b0;
        r.err   = !is_legal(o.addr);
        r.rdata = 32'h0;
        if (is_legal(o.addr)) begin
            w        = int'(o.addr / 4);
            ac.addr  = AW'(w);
            ac.we    = r.we;
            ac.wdata = is_data ? o.wdata : 32'h0;
            acc_q.push_back(ac);
            if (r.we) model_mem[w] = o.wdata;
            else      r.rdata = model_mem[w];
        end
        if (is_data) mem_q.push_back(r);
        else         imem_q.push_back(r);
        order_q.push_back(is_data);
    endtask

    task automatic flush_queues();
        mem_q.delete();
        imem_q.delete();
        order_q.delete();
        acc_q.delete();
    endtask

    task automatic drive_data();
        int n;
        for (int i = 0; i < dq.size(); i++) begin
            mem_valid = 1'b1;
            mem_we    = dq[i].we;
            mem_addr  = dq[i].addr;
            mem_wdata = dq[i].wdata;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_ready && n < 100);
            if (!mem_ready) begin
                fail_now("data_timeout");
                mem_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
        mem_we    = 1'b0;
    endtask

    task automatic drive_fetch();
        int n;
        for (int i = 0; i < fq.size(); i++) begin
            imem_valid = 1'b1;
            imem_addr  = fq[i].addr;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!imem_ready && n < 100);
            if (!imem_ready) begin
                fail_now("fetch_timeout");
                imem_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        imem_valid = 1'b0;
    endtask

    // Predict the grant sequence for the whole batch, then drive both ports
    // at once and let the monitor compare.
    task automatic run_batch();
        int di;
        int fi;
        int nd;
        int nf;
        int n;
        bit take_d;
        di = 0;
        fi = 0;
        nd = dq.size();
        nf = fq.size();
        if (nd + nf == 0) return;
        while (di < nd || fi < nf) begin
            if (di < nd && fi < nf) take_d = (model_streak < MAXS);
            else                    take_d = (di < nd);
            if (take_d && fi < nf) begin
                if (model_streak < (1 << SW) - 1) model_streak++;
            end else begin
                model_streak = 0;
            end
            if (take_d) begin
                predict(1'b1, dq[di]);
                di++;
            end else begin
                predict(1'b0, fq[fi]);
                fi++;
            end
        end
        @(posedge clk);
        #1;
        busy_cycles = 0;
        fork
            drive_data();
            drive_fetch();
        join
        n = 0;
        while (order_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("batch_drain", order_q.size(), 0);
        check("busy_cycles", busy_cycles, 2 * (nd + nf));
        flush_queues();
        dq.delete();
        fq.delete();
    endtask

    // Monitor: compare each SRAM strobe and each ready against the queues.
    initial begin
        acc_t  a;
        resp_t r;
        bit    p;
        bit    is_data;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_cycles++;
                if (sram_en) begin
                    if (acc_q.size() == 0) begin
                        fail_now("sram_spurious");
                    end else begin
                        a = acc_q.pop_front();
                        check("sram_addr", sram_addr, a.addr);
                        check("sram_we", sram_we, a.we);
                        check("sram_wdata", sram_wdata, a.wdata);
                    end
                end
                if (imem_ready || mem_ready) begin
                    check("ready_exclusive", imem_ready && mem_ready, 0);
                    is_data = mem_ready;
                    if (order_q.size() == 0 || (is_data ? mem_q.size() : imem_q.size()) == 0) begin
                        fail_now("ready_spurious");
                    end else begin
                        p = order_q.pop_front();
                        check("grant_order", is_data, p);
                        r = is_data ? mem_q.pop_front() : imem_q.pop_front();
                        check(is_data ? "mem_rdata" : "imem_rdata",
                              is_data ? mem_rdata : imem_rdata, r.rdata);
                        check(is_data ? "mem_err" : "imem_err",
                              is_data ? mem_err : imem_err, r.err);
                        $display("[TB] t=%0t %s %s addr=%h rdata=%h err=%0d", $time,
                                 is_data ? "DATA " : "FETCH", r.we ? "wr" : "rd", r.addr,
                                 is_data ? mem_rdata : imem_rdata, is_data ? mem_err : imem_err);
                    end
                end else begin
                    check("quiet_outputs", |{imem_rdata, imem_err, mem_rdata, mem_err}, 0);
                end
            end
        end
    end

    initial begin
        int  n;
        int  wc0;
        int  nd;
        int  nf;
        op_t o;
        acc_t ac;

        // Reset with the SRAM and the model preloaded with identical contents.
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            preload_en   = 1'b1;
            preload_addr = AW'(i);
            preload_data = (i == 2) ? 32'h0000_0013 : $urandom;
            model_mem[i] = preload_data;
        end
        @(negedge clk);
        preload_en = 1'b0;
        check("reset_outputs", outs_or(), 0);
        rst_n = 1'b1;

        // Single fetch of word 2.
        fq.push_back(mk(1'b0, 32'h8, 32'h0));
        run_batch();

        // Data write followed by a read-back.
        dq.push_back(mk(1'b1, 32'h4, 32'h0000_0100));
        run_batch();
        dq.push_back(mk(1'b0, 32'h4, 32'h0));
        run_batch();

        // Contention: both ports held, so the grant order is D,D,D,D,I,D,D,D,D,I.
        for (int i = 0; i < 8; i++)
            dq.push_back(mk(1'($urandom_range(0, 1)), 32'(32 + 4 * i), $urandom));
        fq.push_back(mk(1'b0, 32'h8, 32'h0));
        fq.push_back(mk(1'b0, 32'h4, 32'h0));
        run_batch();

        // Illegal addresses: no strobe, err set, and the aliased words are unchanged.
        dq.push_back(mk(1'b1, 32'h400, 32'hDEAD_BEEF));
        dq.push_back(mk(1'b1, 32'h6, 32'hBAD0_0006));
        dq.push_back(mk(1'b0, 32'h6, 32'h0));
        dq.push_back(mk(1'b0, 32'h0, 32'h0));
        dq.push_back(mk(1'b0, 32'h4, 32'h0));
        run_batch();

        // Reset during ACCESS while the write request is held.
        @(posedge clk);
        #1;
        o = mk(1'b1, 32'h10, 32'hCAFE_0006);
        ac.addr  = AW'(4);
        ac.we    = 1'b1;
        ac.wdata = o.wdata;
        acc_q.push_back(ac);
        predict(1'b1, o);
        wc0 = wr_count;
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = o.addr;
        mem_wdata = o.wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sram_en && n < 10);
        check("rst_access_seen", sram_en, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs_or(), 0);
        model_streak = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 20);
        check("rst_served", mem_ready, 1);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_single_write", wr_count - wc0, 1);
        check("rst_drain", order_q.size(), 0);
        flush_queues();
        dq.push_back(mk(1'b0, 32'h10, 32'h0));
        run_batch();

        // Randomised mixed traffic.
        for (int b = 0; b < 25; b++) begin
            nd = $urandom_range(0, 6);
            nf = $urandom_range(0, 4);
            for (int i = 0; i < nd; i++)
                dq.push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom));
            for (int i = 0; i < nf; i++)
                fq.push_back(mk(1'b0, rand_addr(), 32'h0));
            run_batch();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qar_mem_arbiter.md
Name: qar_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the qar_core instruction-fetch port (imem_*) and data port (mem_*), giving a unified von Neumann memory.
- Sits between qar_core (built with USE_INTERNAL_IMEM=0 and USE_INTERNAL_DMEM=0) and one SRAM macro or behavioural array.
- Arbitrates with data priority and a starvation guard for fetch, sequences each SRAM access, and returns per-port ready/rdata with range checking.

Parameters:
DEPTH, 64, SRAM depth in 32-bit words
ADDR_WIDTH, 6, SRAM word-address width; log2(DEPTH)
MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending
STREAK_WIDTH, 3, width of the streak counter; must hold MAX_DATA_STREAK

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_valid  in  1  fetch request; held with imem_addr until imem_ready
imem_addr  in  32  fetch byte address
imem_ready  out  1  one-cycle completion pulse for fetch
imem_rdata  out  32  fetch data; valid only while imem_ready=1, else 0
imem_err  out  1  pulses with imem_ready when the fetch address is illegal
mem_valid  in  1  data request; held with addr/we/wdata until mem_ready
mem_we  in  1  1 = word write, 0 = read
mem_addr  in  32  data byte address
mem_wdata  in  32  write data
mem_ready  out  1  one-cycle completion pulse for data
mem_rdata  out  32  read data; valid only while mem_ready=1 on a read, else 0
mem_err  out  1  pulses with mem_ready when the data address is illegal
sram_en  out  1  SRAM access strobe
sram_we  out  1  SRAM write enable; qualified by sram_en
sram_addr  out  ADDR_WIDTH  SRAM word address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid the cycle after the sampling edge
busy  out  1  high in ACCESS and RESP

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, streak=0, and every output is 0.
- Reset mid-operation: the in-flight transaction is abandoned and no ready is issued. A requester still holding valid after release is re-arbitrated and served exactly once.
- Address decode: word index = addr[ADDR_WIDTH+1:2].
- An address is illegal if addr[1:0]!=0, if addr[31:ADDR_WIDTH+2]!=0, or if the word index >= DEPTH.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no valid is high, stay in IDLE.
  - Otherwise select an owner and register it: sram_we (mem_we for data, 0 for fetch), sram_addr, sram_wdata (0 for fetch), and the illegal flag.
  - At the same edge, set sram_en=1 only if the address is legal, then go to ACCESS.
- ACCESS: lasts one cycle. sram_en is high for this cycle only. At the end edge, clear sram_en and go to RESP.
- RESP: lasts one cycle.
  - The owner's ready is 1.
  - Read data: owner rdata = sram_rdata for a legal read, 0 for a write or illegal access.
  - The owner's err equals the illegal flag.
  - At the end edge, go to IDLE.
- Latency: valid high at edge E0 in IDLE → SRAM samples at E1 → ready high in the cycle after E1 and sampled at E2. Throughput is one access per 3 cycles.
- Arbitration when only one valid is high: grant that port.
- Arbitration when both are high: grant data unless streak >= MAX_DATA_STREAK, in which case grant fetch.
- Streak counter updates at the grant edge:
  - fetch grant → 0
  - data grant with imem_valid=1 → increment, saturating at 2^STREAK_WIDTH-1
  - data grant with imem_valid=0 → 0
- Request sampling: valid and payload are sampled only in IDLE. Changes during ACCESS or RESP are ignored. A request dropped before being granted is never served.
- Ready exclusivity: imem_ready and mem_ready are never high in the same cycle. No ready is generated without a granted request.
- Illegal write: no SRAM write occurs. ready and err still pulse with the normal 2-edge latency.

Test Plan:
1. Reset: assert rst_n=0 mid-sim → all outputs 0 asynchronously, before the next clk edge.
2. Fetch: SRAM word2=0x00000013, imem_addr=0x8 → sram_en=1, sram_addr=2, sram_we=0 for one cycle; next cycle imem_ready=1, imem_rdata=0x13, imem_err=0; busy high for 2 cycles.
3. Data write then read:
   - mem_addr=0x4, mem_we=1, wdata=0x00000100 → sram_we=1, sram_addr=1, mem_ready pulse, mem_rdata=0.
   - Then a read of 0x4 → mem_rdata=0x00000100.
4. Contention: imem_valid and mem_valid held high, MAX_DATA_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; never two readys in one cycle.
5. Illegal addresses: mem_addr=0x400 and mem_addr=0x6 → sram_en stays 0; mem_ready=1 and mem_err=1 together; mem_rdata=0; SRAM contents unchanged.
6. Reset during ACCESS with mem_valid held → no mem_ready before reset; after release exactly one write is performed and exactly one mem_ready pulse is issued.
